// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose:
//   Bundles the decode/execute/memory-stage observations that feed the
//   hazard sequencer, together with the stall/flush controls and status it
//   returns to the pipeline registers.
//
// Modports:
//   master : pipeline side. Drives the stage observations and samples the
//            stall/flush controls and status.
//   slave  : hazard sequencer side (pipe_hazard_ctrl).
//
// Signal summary:
//   rs_d, rt_d, uses_rs_d, uses_rt_d      decode-stage source operands
//   reg_write_e, mem_to_reg_e, write_reg_e execute-stage destination info
//   branch_taken_e                         branch/jump in EX resolved taken
//   md_start_e, md_op_e                    mul/div in EX (0 = mul, 1 = div)
//   mem_req_m, mem_ack                     data-memory access and completion
//   stall_f/d/e/m                          hold PC, F_D, D_E, E_M
//   flush_d/e/m/w                          bubble into F_D, D_E, E_M, M_W
//   md_busy, md_done, ctrl_state           sequencer status
//   stall_cycles                           saturating count of fetch stalls
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  // Stage observations
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        uses_rs_d;
  logic        uses_rt_d;
  logic        reg_write_e;
  logic        mem_to_reg_e;
  logic [4:0]  write_reg_e;
  logic        branch_taken_e;
  logic        md_start_e;
  logic        md_op_e;
  logic        mem_req_m;
  logic        mem_ack;

  // Pipeline-register controls
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        flush_d;
  logic        flush_e;
  logic        flush_m;
  logic        flush_w;

  // Status
  logic        md_busy;
  logic        md_done;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  modport master (
    output rs_d, rt_d, uses_rs_d, uses_rt_d,
    output reg_write_e, mem_to_reg_e, write_reg_e,
    output branch_taken_e, md_start_e, md_op_e,
    output mem_req_m, mem_ack,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_m, flush_w,
    input  md_busy, md_done, ctrl_state, stall_cycles
  );

  modport slave (
    input  rs_d, rt_d, uses_rs_d, uses_rt_d,
    input  reg_write_e, mem_to_reg_e, write_reg_e,
    input  branch_taken_e, md_start_e, md_op_e,
    input  mem_req_m, mem_ack,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_m, flush_w,
    output md_busy, md_done, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Central stall/flush sequencer for a five-stage MIPS pipeline with a
//   branch delay slot. It resolves, in priority order:
//     1. data-memory wait states (M held, bubble into M_W),
//     2. multi-cycle mul/div occupancy of EX (bubble into E_M),
//     3. load-use interlock (one bubble into D_E),
//     4. taken-branch squash of the wrong-path fetch (bubble into F_D).
//   It also counts fetch-stall cycles in a saturating 32-bit counter.
//
// Parameters:
//   MUL_CYCLES : total cycles a mul occupies EX (2..63)
//   DIV_CYCLES : total cycles a div occupies EX (2..63)
//
// Ports:
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset; also forces every stall/flush
//            output and md_busy/md_done low while asserted
//   hz     : pipe_hazard_ctrl_if.slave, stage observations in, controls and
//            status out
//
// State:
//   state_q        : RUN / MD_WAIT / MEM_WAIT
//   md_cnt_q       : remaining MD_WAIT cycles before the final mul/div cycle
//   stall_cycles_q : saturating count of cycles with stall_f high
// All other outputs are combinational from state and inputs.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic                clk,
  input  logic                resetn,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MD_WAIT  = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  // The RUN cycle that accepts a mul/div is its first EX cycle and the
  // md_cnt==0 cycle is its last, so the counter starts at N-2.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  state_e      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Raw controls before reset gating
  logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic flush_d_c, flush_e_c, flush_m_c, flush_w_c;
  logic md_done_c;
  logic load_use;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Load in EX whose destination is read by the instruction in D.
  // $0 never creates a dependency.
  always_comb begin
    load_use = hz.reg_write_e && hz.mem_to_reg_e && (hz.write_reg_e != 5'd0) &&
               ((hz.uses_rs_d && (hz.rs_d == hz.write_reg_e)) ||
                (hz.uses_rt_d && (hz.rt_d == hz.write_reg_e)));
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    stall_m_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_m_c = 1'b0;
    flush_w_c = 1'b0;
    md_done_c = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.mem_req_m && !hz.mem_ack) begin
          // Whole pipeline up to M holds; W receives bubbles.
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          stall_m_c = 1'b1;
          flush_w_c = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else if (hz.md_start_e) begin
          // EX holds the mul/div; M receives bubbles behind it.
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
          md_cnt_d  = hz.md_op_e ? DIV_LOAD : MUL_LOAD;
          state_d   = ST_MD_WAIT;
        end else if (load_use) begin
          // Hold D for one cycle and let EX take a bubble.
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // EX is frozen here, so a mul/div in EX is picked up again in RUN.
        if (!hz.mem_ack) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          stall_m_c = 1'b1;
          flush_w_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_MD_WAIT: begin
        // M only holds bubbles here, so memory requests cannot occur.
        if (md_cnt_q != 6'd0) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
          md_cnt_d  = md_cnt_q - 6'd1;
        end else begin
          md_done_c = 1'b1;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d  = ST_RUN;
        md_cnt_d = 6'd0;
      end
    endcase

    // Delay-slot architecture: only the wrong-path fetch is squashed, and
    // only when the branch actually leaves EX this cycle.
    flush_d_c = hz.branch_taken_e && !stall_e_c;
  end

  always_comb begin
    stall_cycles_d = stall_f_c ? sat_inc32(stall_cycles_q) : stall_cycles_q;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_RUN;
      md_cnt_q       <= 6'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Outputs, forced quiet while reset is held
  always_comb begin
    hz.stall_f      = resetn && stall_f_c;
    hz.stall_d      = resetn && stall_d_c;
    hz.stall_e      = resetn && stall_e_c;
    hz.stall_m      = resetn && stall_m_c;
    hz.flush_d      = resetn && flush_d_c;
    hz.flush_e      = resetn && flush_e_c;
    hz.flush_m      = resetn && flush_m_c;
    hz.flush_w      = resetn && flush_w_c;
    hz.md_done      = resetn && md_done_c;
    hz.md_busy      = resetn && (state_q == ST_MD_WAIT);
    hz.ctrl_state   = state_q;
    hz.stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 33;

  // Bit positions in the packed output vector
  localparam int B_SF = 11, B_SD = 10, B_SE = 9, B_SM = 8;
  localparam int B_FD = 7, B_FE = 6, B_FM = 5, B_FW = 4;
  localparam int B_BUSY = 3, B_DONE = 2;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       m2r;
    logic [4:0] wr;
    logic       bt;
    logic       mds;
    logic       mdop;
    logic       mreq;
    logic       ack;
  } in_t;

  logic clk;
  logic resetn;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: mode 0 = running, 1 = mul/div occupying EX, 2 = waiting
  // on memory. For a mul/div the model tracks its total length and how many
  // EX cycles it has already used.
  int     m_mode;
  int     m_len;
  int     m_age;
  longint m_cnt;

  logic [11:0] last_o;
  logic [31:0] last_cnt;

  function automatic in_t idle_in();
    in_t i;
    i = '0;
    return i;
  endfunction

  function automatic logic [11:0] model_out(input in_t i);
    logic sf, sd, se, sm, fe, fm, fw, dn, lu;
    sf = 0; sd = 0; se = 0; sm = 0; fe = 0; fm = 0; fw = 0; dn = 0;
    lu = i.rw && i.m2r && (i.wr != 0) &&
         ((i.urs && i.rs == i.wr) || (i.urt && i.rt == i.wr));
    if (m_mode == 0) begin
      if (i.mreq && !i.ack) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (i.mds) begin
        sf = 1; sd = 1; se = 1; fm = 1;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
      end
    end else if (m_mode == 1) begin
      if (m_age == m_len - 1) dn = 1;
      else begin
        sf = 1; sd = 1; se = 1; fm = 1;
      end
    end else begin
      if (!i.ack) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end
    end
    return {sf, sd, se, sm, (i.bt && !se), fe, fm, fw, (m_mode == 1), dn, 2'(m_mode)};
  endfunction

  task automatic model_adv(input in_t i, input logic sf);
    if (m_mode == 0) begin
      if (i.mreq && !i.ack) m_mode = 2;
      else if (i.mds) begin
        m_mode = 1;
        m_len  = i.mdop ? DIV_N : MUL_N;
        m_age  = 1;
      end
    end else if (m_mode == 1) begin
      if (m_age == m_len - 1) m_mode = 0;
      else m_age = m_age + 1;
    end else begin
      if (i.ack) m_mode = 0;
    end
    if (sf && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_age = 0; m_cnt = 0;
  endtask

  task automatic apply(input in_t i);
    bus.rs_d           = i.rs;
    bus.rt_d           = i.rt;
    bus.uses_rs_d      = i.urs;
    bus.uses_rt_d      = i.urt;
    bus.reg_write_e    = i.rw;
    bus.mem_to_reg_e   = i.m2r;
    bus.write_reg_e    = i.wr;
    bus.branch_taken_e = i.bt;
    bus.md_start_e     = i.mds;
    bus.md_op_e        = i.mdop;
    bus.mem_req_m      = i.mreq;
    bus.mem_ack        = i.ack;
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
            bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w,
            bus.md_busy, bus.md_done, bus.ctrl_state};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive just after the rising edge, compare on the
  // falling edge, then advance the model to match the next rising edge.
  task automatic step(input in_t i);
    logic [11:0] exp_o;
    apply(i);
    exp_o = model_out(i);
    @(negedge clk);
    last_o   = dut_out();
    last_cnt = bus.stall_cycles;
    vectors++;
    if (last_o !== exp_o || last_cnt !== m_cnt[31:0]) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: outs got %b want %b, stall_cycles got %h want %h",
               $time, last_o, exp_o, last_cnt, m_cnt[31:0]);
    end
    model_adv(i, exp_o[B_SF]);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t hazard_in();
    in_t h;
    h = '0;
    h.rw = 1; h.m2r = 1; h.wr = 5'd8; h.rs = 5'd8; h.urs = 1;
    h.bt = 1; h.mds = 1; h.mreq = 1; h.ack = 0;
    return h;
  endfunction

  // Entered and left just after a rising edge. Inputs are held at every
  // hazard during reset to show that the outputs stay quiet.
  task automatic do_reset(input string name);
    apply(hazard_in());
    resetn = 1'b0;
    #2;
    chk({name, "_outs_in_reset"}, {20'd0, dut_out()}, 32'd0);
    chk({name, "_cnt_in_reset"}, bus.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    apply(idle_in());
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t i;
    int se_n, busy_n, done_n, done_at, sm_n, fw_n;

    resetn = 1'b0;
    apply(idle_in());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    step(idle_in());
    chk("reset_outs", {20'd0, last_o}, 32'd0);
    chk("reset_cnt", last_cnt, 32'd0);

    // Load-use: lw $8 in EX, D reads rs=8
    i = idle_in();
    i.rw = 1; i.m2r = 1; i.wr = 5'd8; i.rs = 5'd8; i.urs = 1;
    step(i);
    chk("lu_stall_f", {31'd0, last_o[B_SF]}, 32'd1);
    chk("lu_stall_d", {31'd0, last_o[B_SD]}, 32'd1);
    chk("lu_flush_e", {31'd0, last_o[B_FE]}, 32'd1);
    chk("lu_stall_e", {31'd0, last_o[B_SE]}, 32'd0);
    step(idle_in());
    chk("lu_cnt", last_cnt, 32'd1);
    chk("lu_state", {30'd0, last_o[1:0]}, 32'd0);
    // $0 destination never interlocks
    i.wr = 5'd0; i.rs = 5'd0;
    step(i);
    chk("lu_r0", {31'd0, last_o[B_SF]}, 32'd0);

    // Mul occupancy
    do_reset("mul");
    se_n = 0; busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 6; k++) begin
      i = idle_in();
      i.mds = (k <= MUL_N);
      step(i);
      se_n   += int'(last_o[B_SE]);
      busy_n += int'(last_o[B_BUSY]);
      if (last_o[B_DONE]) begin done_n++; done_at = k; end
    end
    chk("mul_stall_e_cycles", se_n, 3);
    chk("mul_busy_cycles", busy_n, 3);
    chk("mul_done_at", done_at, 4);
    chk("mul_done_count", done_n, 1);

    // Div occupancy
    do_reset("div");
    se_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= DIV_N + 3; k++) begin
      i = idle_in();
      i.mds = (k <= DIV_N); i.mdop = 1;
      step(i);
      se_n += int'(last_o[B_SE]);
      if (last_o[B_DONE]) begin done_n++; done_at = k; end
    end
    chk("div_done_at", done_at, 33);
    chk("div_stall_e_cycles", se_n, 32);
    chk("div_done_count", done_n, 1);

    // Memory wait, ack low for 5 cycles
    do_reset("mem");
    sm_n = 0; fw_n = 0;
    for (int k = 1; k <= 6; k++) begin
      i = idle_in();
      i.mreq = 1; i.ack = (k == 6);
      step(i);
      sm_n += int'(last_o[B_SM]);
      fw_n += int'(last_o[B_FW]);
      if (k == 6) chk("mem_ack_cycle_stall", {31'd0, last_o[B_SF]}, 32'd0);
    end
    chk("mem_stall_m_cycles", sm_n, 5);
    chk("mem_flush_w_cycles", fw_n, 5);
    step(idle_in());
    chk("mem_cnt", last_cnt, 32'd5);
    chk("mem_state", {30'd0, last_o[1:0]}, 32'd0);

    // Memory wait together with a mul
    do_reset("memmul");
    done_n = 0; done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      i = idle_in();
      i.mreq = (k <= 3); i.ack = (k == 3); i.mds = (k <= 7);
      step(i);
      if (k == 2) chk("memmul_state_k2", {30'd0, last_o[1:0]}, 32'd2);
      if (k == 5) chk("memmul_busy_k5", {31'd0, last_o[B_BUSY]}, 32'd1);
      if (last_o[B_DONE]) begin done_n++; done_at = k; end
    end
    chk("memmul_done_at", done_at, 7);
    chk("memmul_done_count", done_n, 1);

    // Branch in RUN
    do_reset("br");
    i = idle_in(); i.bt = 1;
    step(i);
    chk("br_flush_d", {31'd0, last_o[B_FD]}, 32'd1);
    chk("br_flush_e", {31'd0, last_o[B_FE]}, 32'd0);
    step(idle_in());

    // Branch during memory wait is deferred to the ack cycle
    for (int k = 1; k <= 3; k++) begin
      i = idle_in();
      i.bt = 1; i.mreq = 1; i.ack = (k == 3);
      step(i);
      chk($sformatf("brmem_flush_d_k%0d", k), {31'd0, last_o[B_FD]}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a div (md_cnt at 10)
    do_reset("mdrst_pre");
    for (int k = 1; k <= 22; k++) begin
      i = idle_in();
      i.mds = 1; i.mdop = 1;
      step(i);
    end
    do_reset("mdrst");
    step(idle_in());
    chk("mdrst_state_after", {30'd0, last_o[1:0]}, 32'd0);
    chk("mdrst_busy_after", {31'd0, last_o[B_BUSY]}, 32'd0);

    // Counter saturation
    do_reset("sat");
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    m_cnt = 64'hFFFF_FFFE;
    for (int k = 1; k <= 4; k++) begin
      i = idle_in();
      i.mreq = 1; i.ack = (k == 4);
      step(i);
    end
    step(idle_in());
    chk("sat_cnt", last_cnt, 32'hFFFF_FFFF);

    // Randomised traffic against the model
    do_reset("rand");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
      i = idle_in();
      i.rs   = 5'($urandom_range(0, 3));
      i.rt   = 5'($urandom_range(0, 3));
      i.wr   = 5'($urandom_range(0, 3));
      i.urs  = 1'($urandom_range(0, 1));
      i.urt  = 1'($urandom_range(0, 1));
      i.rw   = 1'($urandom_range(0, 1));
      i.m2r  = 1'($urandom_range(0, 1));
      i.bt   = ($urandom_range(0, 3) == 0);
      i.mds  = ($urandom_range(0, 9) == 0);
      i.mdop = ($urandom_range(0, 5) == 0);
      i.mreq = ($urandom_range(0, 2) == 0);
      i.ack  = 1'($urandom_range(0, 1));
      step(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It watches the decode, execute and memory stages and drives the stall and flush controls of the F_D, D_E, E_M and M_W pipeline registers. It covers load-use interlocks, taken-branch squashing (delay-slot architecture, resolved in EX), multi-cycle mul/div occupancy of EX, and data-memory wait states. It also keeps a saturating stall-cycle counter.

## Interface
- MUL_CYCLES, 4, total cycles a mul occupies EX; legal range 2..63
- DIV_CYCLES, 33, total cycles a div occupies EX; legal range 2..63
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset; one clock domain only
- rs_d, rt_d  in  5 each  source register numbers in D
- uses_rs_d, uses_rt_d  in  1 each  D instruction reads rs/rt
- reg_write_e, mem_to_reg_e  in  1 each  EX instruction writes a register / is a load
- write_reg_e  in  5  destination register of the EX instruction
- branch_taken_e  in  1  branch/jump in EX resolved taken
- md_start_e  in  1  EX holds a mul/div
- md_op_e  in  1  0 = mul, 1 = div
- mem_req_m  in  1  M holds a load/store
- mem_ack  in  1  data memory completes the access this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC, F_D, D_E, E_M
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into F_D, D_E, E_M, M_W
- md_busy  out  1  FSM in MD_WAIT
- md_done  out  1  final EX cycle of a mul/div
- ctrl_state  out  2  RUN = 00, MD_WAIT = 01, MEM_WAIT = 10
- stall_cycles  out  32  count of cycles with stall_f = 1, saturating

## Operation
- Registered state: ctrl_state, 6-bit md_cnt, stall_cycles. All other outputs are combinational from state and inputs.
- Priority inside RUN: memory wait, then mul/div, then load-use, then branch.
- **RUN, mem_req_m=1 and mem_ack=0:**
  - stall_f/d/e/m=1, flush_w=1.
  - Next state MEM_WAIT.
- **RUN, md_start_e=1 (no memory wait):**
  - stall_f/d/e=1, flush_m=1.
  - md_cnt <= (md_op_e ? DIV_CYCLES : MUL_CYCLES) − 2.
  - Next state MD_WAIT.
- **RUN, load-use:**
  - Condition: reg_write_e & mem_to_reg_e & write_reg_e≠0 & ((uses_rs_d & rs_d==write_reg_e) | (uses_rt_d & rt_d==write_reg_e)).
  - Response: stall_f/d=1, flush_e=1.
- **Branch:** flush_d = branch_taken_e & ~stall_e. Only the fetched wrong-path instruction is squashed. The delay slot in D proceeds.
- **MEM_WAIT:**
  - While mem_ack=0: stall_f/d/e/m=1, flush_w=1.
  - On mem_ack=1: all stalls 0, next state RUN.
  - md_start_e is ignored here and re-evaluated in RUN, because EX is held.
- **MD_WAIT:**
  - While md_cnt≠0: stall_f/d/e=1, flush_m=1, md_cnt−1.
  - When md_cnt==0: md_done=1, stalls 0, next state RUN.
  - md_start_e and mem_req_m are ignored here. M holds bubbles.
- **Occupancy:** a mul/div occupies EX for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES): one RUN cycle plus N−1 MD_WAIT cycles.
- **Back-to-back mul/div:** the second is seen in RUN on the cycle after md_done and starts a new sequence.
- **Simultaneous memory wait and mul/div:** MEM_WAIT is served first. On return to RUN, md_start_e is still asserted and the MD sequence begins.
- **stall_cycles:** +1 on every clk edge where stall_f=1, saturating at 0xFFFFFFFF.
- md_busy = (ctrl_state==MD_WAIT).

## Timing
- **Reset:**
  - resetn low asynchronously sets ctrl_state=RUN, md_cnt=0, stall_cycles=0.
  - While resetn=0, every stall/flush output, md_done and md_busy are forced to 0.
  - Reset mid-MD_WAIT or mid-MEM_WAIT aborts the sequence immediately. After release, decoding restarts in RUN.
- **Load-use:** costs exactly 1 bubble.
- **Memory wait:** costs one stall cycle per cycle mem_ack is low.
- **Combinational paths:** outputs respond in the same cycle as inputs. State changes on the rising clk edge.

## Test plan
- **Load-use:** lw writes $8 in EX; D reads rs=8 with uses_rs_d=1 → one cycle of stall_f=stall_d=flush_e=1; stall_cycles=1; state stays RUN.
- **Mul/div occupancy:**
  - md_start_e=1, md_op_e=0 with MUL_CYCLES=4 → stall_e high for 3 cycles, md_done on the 4th, md_busy high for 3 cycles.
  - Same with div and DIV_CYCLES=33 → md_done on cycle 33.
- **Memory wait:** mem_req_m=1 with mem_ack low for 5 cycles → stall_f/d/e/m and flush_w high for 5 cycles; they drop in the ack cycle; state returns to RUN; stall_cycles=5.
- **Memory wait and mul together:** mem_req_m=1 with mem_ack delayed 2 cycles, and md_start_e=1 (mul, MUL_CYCLES=4) in the same cycle → MEM_WAIT for 2 cycles, then 4-cycle MD sequence; md_done fires exactly once.
- **Branch:**
  - branch_taken_e=1 in RUN with no hazard → flush_d=1 for 1 cycle; flush_e=0.
  - Same branch during MEM_WAIT → flush_d deferred to the ack cycle.
- **Reset and saturation:**
  - Assert resetn=0 mid-MD_WAIT (md_cnt=10) → all outputs 0 immediately; after release, state RUN.
  - Force stall_cycles to 0xFFFFFFFE, then 3 stall cycles → value holds at 0xFFFFFFFF.
